// File: rtl/game_pkg.sv
// Shared constants for the arrow game: FSM state encodings, arrow codes
// and 7-segment patterns used across the top-level blocks.
package game_pkg;

  localparam int STATE_BITS = 1;

  typedef enum logic [STATE_BITS:0] {
    ST_IDLE = 2'd0,
    ST_GAME = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [STATE_BITS:0] STATE_GAME = ST_GAME;

  typedef enum logic [1:0] {
    ARW_UP    = 2'd0,
    ARW_DOWN  = 2'd1,
    ARW_LEFT  = 2'd2,
    ARW_RIGHT = 2'd3
  } arrow_e;

  // Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_div_toggle_divider.sv
// Square-wave divider: q toggles every HALF enabled cycles, tick marks the wrap edge.
// Latency: first toggle on the HALF-th enabled edge; no backpressure, en=0 clears synchronously.
module toggle_divider #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic q,
  output logic tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  if (HALF < 2) begin : g_half_chk
    $error("toggle_divider: HALF must be at least 2");
  end

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  // tick is combinational so dependent flops can act on the same edge as the toggle.
  assign w_wrap = en && (r_cnt == CW'(HALF - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      q     <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      q     <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      q     <= ~q;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clock_div.sv
// Game-tempo (4/2/1 Hz, phase-aligned, run only in the game state) and display clocks.
// Latency: tempo clocks clear one edge after leaving the game state; no backpressure.
module clock_div #(
  parameter int                    CLK_FREQ   = 100_000_000,
  parameter int                    DISPLAY_HZ = 500,
  parameter int                    STATE_BITS = game_pkg::STATE_BITS,
  parameter logic [STATE_BITS:0]   STATE_GAME = game_pkg::STATE_GAME
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [STATE_BITS:0]   state,
  output logic                  fourHz_CLK,
  output logic                  twoHz_CLK,
  output logic                  oneHz_CLK,
  output logic                  display_CLK
);

  import game_pkg::*;

  localparam int HALF4 = CLK_FREQ / 8;
  localparam int HALFD = CLK_FREQ / (2 * DISPLAY_HZ);

  logic w_game;
  logic w_tick4;
  logic w_unused_disp_tick;
  logic r_two;
  logic r_one;

  assign w_game = (state == STATE_GAME);

  toggle_divider #(.HALF(HALFD)) u_disp_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (display_CLK),
    .tick  (w_unused_disp_tick)
  );

  toggle_divider #(.HALF(HALF4)) u_four_div (
    .clk   (clk),
    .reset (reset),
    .en    (w_game),
    .q     (fourHz_CLK),
    .tick  (w_tick4)
  );

  // Slower clocks only move on a rising 4 Hz edge, which keeps all three aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_two <= 1'b0;
      r_one <= 1'b0;
    end else if (!w_game) begin
      r_two <= 1'b0;
      r_one <= 1'b0;
    end else if (w_tick4 && !fourHz_CLK) begin
      r_two <= ~r_two;
      if (!r_two) begin
        r_one <= ~r_one;
      end
    end
  end

  assign twoHz_CLK = r_two;
  assign oneHz_CLK = r_one;

endmodule

// File: tb/tb_clock_div.sv
// Directed bench for clock_div with HALF4=100, HALFD=4 (CLK_FREQ=800, DISPLAY_HZ=100).
// Expected waveforms come from closed-form edge-count formulas.
module tb_clock_div;

  localparam int H4 = 100;
  localparam int HD = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state = 2'd1;
  logic       four, two, one, disp;
  logic [3:0] outs;

  int total = 0;
  int bad   = 0;

  assign outs = {four, two, one, disp};

  always #50 clk = ~clk;

  clock_div #(
    .CLK_FREQ   (800),
    .DISPLAY_HZ (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .fourHz_CLK  (four),
    .twoHz_CLK   (two),
    .oneHz_CLK   (one),
    .display_CLK (disp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kt counts edges since the later of reset release / game entry; kd since reset release.
  function automatic logic [3:0] exp_out(input int kt, input int kd, input bit game);
    logic e4, e2, e1, ed;
    e4 = game && (((kt / H4) % 2) != 0);
    e2 = game && ((((kt + H4) / (2 * H4)) % 2) != 0);
    e1 = game && ((((kt + 3 * H4) / (4 * H4)) % 2) != 0);
    ed = ((kd / HD) % 2) != 0;
    return {e4, e2, e1, ed};
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] st);
    reset = 1'b0;
    state = st;
    for (int i = 0; i < 5; i++) begin
      tick_edge();
      check($sformatf("rst_hold c=%0d", i), outs, 4'b0000);
    end
    reset = 1'b1;
  endtask

  task automatic run(input string tag, input int k0, input int k1, input int off, input bit game);
    logic [3:0] prev;
    logic       rise4;
    prev = outs;
    for (int k = k0; k <= k1; k++) begin
      tick_edge();
      check($sformatf("%s k=%0d", tag, k), outs, exp_out(k - off, k, game));
      if (game && k > k0) begin
        rise4 = !prev[3] && outs[3];
        if ((prev[2] != outs[2]) || (prev[1] != outs[1]))
          check($sformatf("%s align k=%0d", tag, k), rise4, 1'b1);
      end
      prev = outs;
    end
  endtask

  initial begin
    // Scenarios 1, 2, 6: reset hold, display start, tempo sequence and alignment.
    start(2'd1);
    run("s2", 1, 1600, 0, 1'b1);

    // Scenario 3: idle state keeps tempo clocks low, display keeps running.
    start(2'd0);
    run("s3", 1, 1000, 0, 1'b0);

    // Scenario 4: leave game after edge 250, re-enter after edge 400.
    start(2'd1);
    run("s4a", 1, 250, 0, 1'b1);
    state = 2'd0;
    run("s4b", 251, 400, 0, 1'b0);
    state = 2'd1;
    run("s4c", 401, 1000, 400, 1'b1);

    // Scenario 5: asynchronous reset between edges, then a clean restart.
    start(2'd1);
    run("s5a", 1, 350, 0, 1'b1);
    #20;
    reset = 1'b0;
    #1;
    check("async_rst", outs, 4'b0000);
    start(2'd1);
    run("s5b", 1, 900, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
